// File: rtl/wb_arbiter.sv
// Writeback arbiter: drives the register file's single write port from the ALU path and a
// buffered slow path (load/mul/div), and tracks pending slow-path destinations for decode.
module wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid_i,
    input  logic [4:0]                 alu_rd_i,
    input  logic [XLEN-1:0]            alu_data_i,
    output logic                       wb_stall_o,
    input  logic                       mem_valid_i,
    output logic                       mem_ready_o,
    input  logic [4:0]                 mem_rd_i,
    input  logic [XLEN-1:0]            mem_data_i,
    input  logic                       issue_en_i,
    input  logic [4:0]                 issue_rd_i,
    input  logic [4:0]                 rs1_addr_i,
    input  logic [4:0]                 rs2_addr_i,
    output logic                       rs1_busy_o,
    output logic                       rs2_busy_o,
    output logic                       wr_en_o,
    output logic [4:0]                 rd_addr_o,
    output logic [XLEN-1:0]            rd_data_o,
    output logic [$clog2(DEPTH):0]     fifo_count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = $clog2(STARVE_LIMIT + 2);
    localparam logic [AW-1:0] AGE_MAX = AW'(STARVE_LIMIT);

    logic [4:0]      q_rd   [DEPTH];
    logic [XLEN-1:0] q_data [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic [AW-1:0]   age;
    logic [31:0]     busy, busy_next;
    logic            fifo_nonempty, push, pop, alu_wr;

    assign fifo_nonempty = (count != '0);
    assign mem_ready_o   = (count < CW'(DEPTH));
    assign wb_stall_o    = fifo_nonempty && (age >= AGE_MAX);
    // Handshakes to x0 complete but never occupy a FIFO slot.
    assign push          = mem_valid_i && mem_ready_o && (mem_rd_i != 5'd0);
    assign fifo_count_o  = count;
    assign rs1_busy_o    = busy[rs1_addr_i];
    assign rs2_busy_o    = busy[rs2_addr_i];

    // Priority: starved FIFO head, then ALU, then FIFO head when the ALU is idle.
    always_comb begin
        pop    = 1'b0;
        alu_wr = 1'b0;
        if (wb_stall_o) begin
            pop = 1'b1;
        end else if (alu_valid_i) begin
            alu_wr = 1'b1;
        end else if (fifo_nonempty) begin
            pop = 1'b1;
        end
    end

    // Clear on pop first so a same-cycle issue to the same register wins.
    always_comb begin
        busy_next = busy;
        if (pop) begin
            busy_next[q_rd[rd_ptr]] = 1'b0;
        end
        if (issue_en_i) begin
            busy_next[issue_rd_i] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]   <= mem_rd_i;
            q_data[wr_ptr] <= mem_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            age       <= '0;
            busy      <= '0;
            wr_en_o   <= 1'b0;
            rd_addr_o <= 5'd0;
            rd_data_o <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pop || !fifo_nonempty) begin
                age <= '0;
            end else if (age != AGE_MAX) begin
                age <= age + 1'b1;
            end
            busy <= busy_next;
            wr_en_o <= 1'b0;
            if (pop) begin
                wr_en_o   <= 1'b1;
                rd_addr_o <= q_rd[rd_ptr];
                rd_data_o <= q_data[rd_ptr];
            end else if (alu_wr && (alu_rd_i != 5'd0)) begin
                wr_en_o   <= 1'b1;
                rd_addr_o <= alu_rd_i;
                rd_data_o <= alu_data_i;
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue/array reference model, per-cycle expected write-port values
// pushed to a scoreboard queue and checked by an independent monitor.
module tb_wb_arbiter;
    localparam int XLEN = 32;
    localparam int DEPTH = 2;
    localparam int STARVE_LIMIT = 3;
    localparam int W = XLEN + 6;

    logic clk = 1'b0;
    logic rst;
    logic alu_valid_i, mem_valid_i, issue_en_i;
    logic [4:0] alu_rd_i, mem_rd_i, issue_rd_i, rs1_addr_i, rs2_addr_i;
    logic [XLEN-1:0] alu_data_i, mem_data_i;
    logic wb_stall_o, mem_ready_o, rs1_busy_o, rs2_busy_o, wr_en_o;
    logic [4:0] rd_addr_o;
    logic [XLEN-1:0] rd_data_o;
    logic [$clog2(DEPTH):0] fifo_count_o;

    wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
        .wb_stall_o(wb_stall_o),
        .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o),
        .mem_rd_i(mem_rd_i), .mem_data_i(mem_data_i),
        .issue_en_i(issue_en_i), .issue_rd_i(issue_rd_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
        .wr_en_o(wr_en_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
        .fifo_count_o(fifo_count_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model state.
    logic [4:0]      mq_rd[$];
    logic [XLEN-1:0] mq_data[$];
    logic [31:0]     m_busy;
    int              m_age;
    logic [4:0]      m_addr;
    logic [XLEN-1:0] m_data;
    logic            alu_held, mem_acc;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        alu_valid_i = 1'b0; alu_rd_i = 5'd0; alu_data_i = '0;
        mem_valid_i = 1'b0; mem_rd_i = 5'd0; mem_data_i = '0;
        issue_en_i = 1'b0; issue_rd_i = 5'd0;
    endtask

    // One clock cycle: check combinational outputs, advance the model, queue the expected write.
    task automatic step();
        logic nonempty, exp_stall, exp_ready, pop, en;
        #1;
        nonempty  = (mq_rd.size() != 0);
        exp_stall = nonempty && (m_age >= STARVE_LIMIT);
        exp_ready = (mq_rd.size() < DEPTH);
        chk("wb_stall", wb_stall_o, exp_stall);
        chk("mem_ready", mem_ready_o, exp_ready);
        chk("fifo_count", fifo_count_o, mq_rd.size());
        chk("rs1_busy", rs1_busy_o, (rs1_addr_i != 0) && m_busy[rs1_addr_i]);
        chk("rs2_busy", rs2_busy_o, (rs2_addr_i != 0) && m_busy[rs2_addr_i]);
        if (rst) begin
            mq_rd.delete(); mq_data.delete();
            m_busy = '0; m_age = 0; m_addr = '0; m_data = '0;
            alu_held = 1'b0; mem_acc = 1'b0;
            exp_q.push_back({1'b0, 5'd0, {XLEN{1'b0}}});
        end else begin
            pop = 1'b0; en = 1'b0;
            if (exp_stall) pop = 1'b1;
            else if (alu_valid_i) begin
                if (alu_rd_i != 0) begin
                    en = 1'b1; m_addr = alu_rd_i; m_data = alu_data_i;
                end
            end else if (nonempty) pop = 1'b1;
            alu_held = alu_valid_i && exp_stall;
            if (pop) begin
                m_addr = mq_rd.pop_front();
                m_data = mq_data.pop_front();
                en = 1'b1;
                m_busy[m_addr] = 1'b0;
            end
            if (issue_en_i && issue_rd_i != 0) m_busy[issue_rd_i] = 1'b1;
            mem_acc = mem_valid_i && exp_ready;
            if (mem_acc && mem_rd_i != 0) begin
                mq_rd.push_back(mem_rd_i);
                mq_data.push_back(mem_data_i);
            end
            if (pop || !nonempty) m_age = 0;
            else m_age++;
            exp_q.push_back({en, m_addr, m_data});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: one expected write-port value per clock edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("wr_en", wr_en_o, mon_e[W-1]);
            chk("rd_addr", rd_addr_o, mon_e[W-2 -: 5]);
            chk("rd_data", rd_data_o, mon_e[XLEN-1:0]);
            chk("x0_write", wr_en_o && (rd_addr_o == 5'd0), 1'b0);
        end
    end

    initial begin
        int pushes;
        int r;
        rst = 1'b1; set_idle(); rs1_addr_i = 5'd0; rs2_addr_i = 5'd0;
        alu_held = 1'b0; mem_acc = 1'b0; m_busy = '0; m_age = 0;
        @(negedge clk);
        step(); step();
        rst = 1'b0;

        // ALU single write then idle.
        alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'hDEADBEEF; step();
        set_idle(); step(); step();

        // Slow op x7: busy until its pop.
        issue_en_i = 1'b1; issue_rd_i = 5'd7; rs1_addr_i = 5'd7; step();
        set_idle(); step(); step();
        mem_valid_i = 1'b1; mem_rd_i = 5'd7; mem_data_i = 32'h1234; step();
        set_idle(); step(); step(); step();

        // Starvation: x3, x4 queued under a continuous ALU stream.
        issue_en_i = 1'b1; issue_rd_i = 5'd3; rs2_addr_i = 5'd3; step();
        issue_rd_i = 5'd4; rs1_addr_i = 5'd4; step();
        set_idle();
        for (int i = 0; i < 20; i++) begin
            alu_valid_i = 1'b1;
            if (!alu_held) begin
                alu_rd_i = 5'($urandom_range(1, 31)); alu_data_i = $urandom;
            end
            mem_valid_i = (i < 2); mem_rd_i = 5'(3 + i); mem_data_i = 32'hA000 + i;
            step();
        end
        set_idle(); step(); step(); step();

        // Fill FIFO, hold valid through backpressure, 10 accepted pushes.
        pushes = 0;
        mem_acc = 1'b1;
        for (int i = 0; i < 60 && pushes < 10; i++) begin
            mem_valid_i = 1'b1;
            if (mem_acc) begin
                mem_rd_i = 5'($urandom_range(1, 31)); mem_data_i = $urandom;
            end
            alu_valid_i = (i < 8);
            if (!alu_held) begin
                alu_rd_i = 5'($urandom_range(0, 31)); alu_data_i = $urandom;
            end
            step();
            if (mem_acc) pushes++;
        end
        chk("ten_pushes", pushes, 10);
        set_idle(); step(); step(); step(); step();

        // Issue x9 in the cycle a queued x9 pops: busy stays set.
        issue_en_i = 1'b1; issue_rd_i = 5'd9; rs1_addr_i = 5'd9; step();
        set_idle(); mem_valid_i = 1'b1; mem_rd_i = 5'd9; mem_data_i = 32'h99; step();
        set_idle(); issue_en_i = 1'b1; issue_rd_i = 5'd9; step();
        set_idle(); step();
        mem_valid_i = 1'b1; mem_rd_i = 5'd9; mem_data_i = 32'h9999; step();
        set_idle(); step(); step();

        // Writes to x0 from both paths.
        alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 32'hFFFF; step();
        set_idle(); mem_valid_i = 1'b1; mem_rd_i = 5'd0; mem_data_i = 32'hEEEE; step();
        set_idle(); step(); step();

        // Reset with entries queued and busy bits set.
        alu_valid_i = 1'b1; alu_rd_i = 5'd1; alu_data_i = 32'h11;
        issue_en_i = 1'b1; issue_rd_i = 5'd10; rs1_addr_i = 5'd10; rs2_addr_i = 5'd11; step();
        issue_rd_i = 5'd11; mem_valid_i = 1'b1; mem_rd_i = 5'd10; mem_data_i = 32'h10; step();
        issue_rd_i = 5'd12; mem_rd_i = 5'd11; mem_data_i = 32'h11; step();
        set_idle(); rst = 1'b1; step();
        rst = 1'b0; step(); step();

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (!alu_held) begin
                alu_valid_i = ($urandom_range(0, 2) != 0);
                alu_rd_i = 5'($urandom_range(0, 31)); alu_data_i = $urandom;
            end
            if (!(mem_valid_i && !mem_acc)) begin
                mem_valid_i = ($urandom_range(0, 1) == 1);
                mem_rd_i = 5'($urandom_range(0, 31)); mem_data_i = $urandom;
            end
            r = $urandom_range(1, 31);
            issue_en_i = ($urandom_range(0, 2) == 0) && !m_busy[r];
            issue_rd_i = 5'(r);
            rs1_addr_i = 5'($urandom_range(0, 31));
            rs2_addr_i = 5'($urandom_range(0, 31));
            step();
        end
        rst = 1'b0; set_idle();
        for (int i = 0; i < 6; i++) step();
        chk("exp_q_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
